// File: rtl/dmem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_arbiter : core/DMA arbiter for the single-port data memory with
//                starvation-forced DMA grants and core load-data hold.
// Revision     : 1.0
// ---------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int D_SIZE       = 32,
   parameter int A_SIZE       = 10,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_read,
   input  logic              core_write,
   input  logic [A_SIZE-1:0] core_address,
   input  logic [D_SIZE-1:0] core_data_out,
   output logic [D_SIZE-1:0] core_data_in,
   output logic              core_stall,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [A_SIZE-1:0] dma_addr,
   input  logic [D_SIZE-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic [D_SIZE-1:0] dma_rdata,
   output logic              dma_rvalid,
   output logic              mem_read,
   output logic              mem_write,
   output logic [A_SIZE-1:0] mem_address,
   output logic [D_SIZE-1:0] mem_data_out,
   input  logic [D_SIZE-1:0] mem_data_in
);

   localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);

   logic [7:0]        starve_cnt_q, starve_cnt_d;
   logic              core_rd_q, core_rd_d;
   logic              dma_rd_q, dma_rd_d;
   logic [D_SIZE-1:0] rdata_hold_q, rdata_hold_d;

   logic core_req, core_rd, force_gnt, dma_own, core_own;

   // Grant and memory mux; everything is gated off while reset is held.
   always_comb begin
      core_req     = core_read | core_write;
      core_rd      = core_read & ~core_write;
      force_gnt    = dma_req && (starve_cnt_q == STARVE_LIM8);
      dma_own      = ~rst & (force_gnt | (~core_req & dma_req));
      core_own     = ~rst & core_req & ~dma_own;

      mem_read     = dma_own ? ~dma_we : (core_own & core_rd);
      mem_write    = dma_own ?  dma_we : (core_own & core_write);
      mem_address  = dma_own ? dma_addr  : core_address;
      mem_data_out = dma_own ? dma_wdata : core_data_out;

      dma_gnt      = dma_own;
      core_stall   = ~rst & force_gnt & core_req;
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!dma_req || dma_gnt) begin
         starve_cnt_d = 8'd0;
      end else if (starve_cnt_q != STARVE_LIM8) begin
         starve_cnt_d = starve_cnt_q + 8'd1;
      end

      core_rd_d    = core_own & core_rd;
      dma_rd_d     = dma_own & ~dma_we;
      rdata_hold_d = core_rd_q ? mem_data_in : rdata_hold_q;

      // A forced DMA read overwrites mem_data_in, so the core sees the hold.
      core_data_in = rst ? '0 : (core_rd_q ? mem_data_in : rdata_hold_q);
      dma_rdata    = mem_data_in;
      dma_rvalid   = dma_rd_q & ~rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= 8'd0;
         core_rd_q    <= 1'b0;
         dma_rd_q     <= 1'b0;
         rdata_hold_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         core_rd_q    <= core_rd_d;
         dma_rd_q     <= dma_rd_d;
         rdata_hold_q <= rdata_hold_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_arbiter : directed table plus corner sequences for dmem_arbiter.
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

   logic        clk;
   logic        rst;
   logic        core_read, core_write;
   logic [9:0]  core_address;
   logic [31:0] core_data_out, core_data_in;
   logic        core_stall;
   logic        dma_req, dma_we;
   logic [9:0]  dma_addr;
   logic [31:0] dma_wdata, dma_rdata;
   logic        dma_gnt, dma_rvalid;
   logic        mem_read, mem_write;
   logic [9:0]  mem_address;
   logic [31:0] mem_data_out, mem_data_in;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] mem [1024];

   dmem_arbiter #(.D_SIZE(32), .A_SIZE(10), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .core_read(core_read), .core_write(core_write),
      .core_address(core_address), .core_data_out(core_data_out),
      .core_data_in(core_data_in), .core_stall(core_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
      .dma_rvalid(dma_rvalid), .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_data_out(mem_data_out),
      .mem_data_in(mem_data_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous single-port memory: one-cycle read latency.
   always @(posedge clk) begin
      if (mem_write) mem[mem_address] <= mem_data_out;
      if (mem_read)  mem_data_in <= mem[mem_address];
   end

   typedef struct {
      logic       rst, crd, cwr, dreq, dwe;
      logic       chk_addr;
      logic       e_rd, e_wr, e_gnt, e_stall;
      logic [9:0] e_addr;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs just after the edge, then wait to mid-cycle.
   task automatic drv(input logic r, input logic crd, input logic cwr,
                      input logic [9:0] ca, input logic [31:0] cd,
                      input logic dq, input logic dw,
                      input logic [9:0] da, input logic [31:0] dd);
      @(posedge clk);
      #1;
      rst = r; core_read = crd; core_write = cwr; core_address = ca;
      core_data_out = cd; dma_req = dq; dma_we = dw; dma_addr = da;
      dma_wdata = dd;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; core_read = 1'b0; core_write = 1'b0; core_address = '0;
      core_data_out = '0; dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0;
      dma_wdata = '0;

      //          rst crd cwr drq dwe chkA rd wr gnt stl addr
      tbl[0]  = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 10'h000};
      tbl[1]  = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 10'h000};
      tbl[2]  = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 10'h000};
      tbl[3]  = '{0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 10'h020};
      tbl[4]  = '{0, 0, 0, 1, 1, 1, 0, 1, 1, 0, 10'h005};
      tbl[5]  = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 10'h020};
      tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000};
      tbl[7]  = '{0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 10'h020};
      tbl[8]  = '{0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 10'h020};
      tbl[9]  = '{0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 10'h020};
      tbl[10] = '{0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 10'h020};
      tbl[11] = '{0, 1, 0, 1, 0, 1, 1, 0, 1, 1, 10'h005};
      tbl[12] = '{0, 0, 0, 1, 0, 1, 1, 0, 1, 0, 10'h005};
      tbl[13] = '{0, 0, 0, 1, 1, 1, 0, 1, 1, 0, 10'h005};
      tbl[14] = '{0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 10'h020};

      for (int i = 0; i < 15; i++) begin
         drv(tbl[i].rst, tbl[i].crd, tbl[i].cwr, 10'h020, 32'h0,
             tbl[i].dreq, tbl[i].dwe, 10'h005, 32'h0);
         chk($sformatf("v%0d mem_read", i),   32'(mem_read),   32'(tbl[i].e_rd));
         chk($sformatf("v%0d mem_write", i),  32'(mem_write),  32'(tbl[i].e_wr));
         chk($sformatf("v%0d dma_gnt", i),    32'(dma_gnt),    32'(tbl[i].e_gnt));
         chk($sformatf("v%0d core_stall", i), 32'(core_stall), 32'(tbl[i].e_stall));
         if (tbl[i].rst) chk($sformatf("v%0d rvalid_rst", i), 32'(dma_rvalid), 32'h0);
         if (tbl[i].chk_addr)
            chk($sformatf("v%0d mem_address", i), 32'(mem_address), 32'(tbl[i].e_addr));
      end

      // Idle DMA write then read-back of 0x05.
      drv(0, 0, 0, 10'h020, 0, 1, 1, 10'h005, 32'hDEADBEEF);
      chk("dmaw gnt", 32'(dma_gnt), 32'h1);
      chk("dmaw mem_write", 32'(mem_write), 32'h1);
      chk("dmaw wdata", mem_data_out, 32'hDEADBEEF);
      drv(0, 0, 0, 10'h020, 0, 1, 0, 10'h005, 32'h0);
      chk("dmar gnt", 32'(dma_gnt), 32'h1);
      chk("dmar mem_read", 32'(mem_read), 32'h1);
      chk("dmar rvalid early", 32'(dma_rvalid), 32'h0);
      drv(0, 0, 0, 10'h020, 0, 0, 0, 10'h005, 32'h0);
      chk("dmar rvalid", 32'(dma_rvalid), 32'h1);
      chk("dmar rdata", dma_rdata, 32'hDEADBEEF);
      drv(0, 0, 0, 10'h020, 0, 0, 0, 10'h005, 32'h0);
      chk("dmar rvalid pulse", 32'(dma_rvalid), 32'h0);

      // Starvation under continuous core reads: forced grants in 4 and 9.
      for (int c = 0; c <= 10; c++) begin
         drv(0, 1, 0, 10'h020, 0, 1, 0, 10'h005, 32'h0);
         chk($sformatf("starve c%0d gnt", c), 32'(dma_gnt), 32'(c == 4 || c == 9));
         chk($sformatf("starve c%0d stall", c), 32'(core_stall), 32'(c == 4 || c == 9));
         if (c == 5) chk("starve c5 cnt", 32'(dut.starve_cnt_q), 32'h0);
      end
      drv(0, 0, 0, 10'h020, 0, 0, 0, 10'h005, 32'h0);

      // Core load of 0x10 followed by a forced DMA read of 0x05.
      drv(0, 0, 1, 10'h010, 32'h1234, 0, 0, 10'h005, 32'h0);
      for (int k = 0; k < 3; k++) drv(0, 0, 1, 10'h030, 32'h0, 1, 0, 10'h005, 32'h0);
      drv(0, 1, 0, 10'h010, 32'h0, 1, 0, 10'h005, 32'h0);
      chk("hold N stall", 32'(core_stall), 32'h0);
      chk("hold N mem_read", 32'(mem_read), 32'h1);
      drv(0, 1, 0, 10'h010, 32'h0, 1, 0, 10'h005, 32'h0);
      chk("hold N+1 gnt", 32'(dma_gnt), 32'h1);
      chk("hold N+1 stall", 32'(core_stall), 32'h1);
      chk("hold N+1 data", core_data_in, 32'h1234);
      drv(0, 0, 0, 10'h010, 32'h0, 0, 0, 10'h005, 32'h0);
      chk("hold N+2 data", core_data_in, 32'h1234);
      chk("hold N+2 rvalid", 32'(dma_rvalid), 32'h1);
      chk("hold N+2 rdata", dma_rdata, 32'hDEADBEEF);

      // Simultaneous core read and write: write wins.
      drv(0, 1, 1, 10'h020, 32'h7, 0, 0, 10'h005, 32'h0);
      chk("rw mem_write", 32'(mem_write), 32'h1);
      chk("rw mem_read", 32'(mem_read), 32'h0);
      chk("rw data", mem_data_out, 32'h7);
      drv(0, 1, 0, 10'h020, 32'h0, 0, 0, 10'h005, 32'h0);
      chk("rw core_rd_q", 32'(dut.core_rd_q), 32'h0);
      drv(0, 0, 0, 10'h020, 32'h0, 0, 0, 10'h005, 32'h0);
      chk("rw readback", core_data_in, 32'h7);

      // Reset arriving while a DMA read is in flight.
      drv(0, 0, 0, 10'h020, 32'h0, 1, 0, 10'h005, 32'h0);
      chk("rstrd gnt", 32'(dma_gnt), 32'h1);
      drv(1, 1, 0, 10'h020, 32'h0, 1, 0, 10'h005, 32'h0);
      chk("rstrd rvalid", 32'(dma_rvalid), 32'h0);
      chk("rstrd core_data", core_data_in, 32'h0);
      chk("rstrd gnt off", 32'(dma_gnt), 32'h0);
      drv(0, 0, 0, 10'h020, 32'h0, 0, 0, 10'h005, 32'h0);
      chk("rstrd rvalid after", 32'(dma_rvalid), 32'h0);
      chk("rstrd starve_cnt", 32'(dut.starve_cnt_q), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
